// File: rtl/motor_drive_ctrl_pkg.sv
// Steering-code constants shared with the direction-control stage, plus the
// controller state encoding and a small elaboration-time helper.
package motor_pkg;

  localparam logic [3:0] DIR_PROCEED      = 4'b0000;
  localparam logic [3:0] DIR_VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] DIR_VEER_LEFT    = 4'b0101;
  localparam logic [3:0] DIR_HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] DIR_HARD_LEFT    = 4'b0110;
  localparam logic [3:0] DIR_NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] DIR_NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] DIR_STOP         = 4'b1111;

  typedef enum logic [2:0] {
    ST_HALT    = 3'd0,
    ST_TRACK   = 3'd1,
    ST_PIVOT_L = 3'd2,
    ST_PIVOT_R = 3'd3,
    ST_BRAKE   = 3'd4
  } drive_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_if.sv
// Steering inputs and H-bridge outputs of the motor drive controller as one bus.
interface motor_drive_ctrl_if;
  logic [3:0] dir_code;
  logic       direction;
  logic       pwm_l;
  logic       pwm_r;
  logic       fwd_l;
  logic       fwd_r;
  logic       busy;

  modport master (output dir_code, direction,
                  input  pwm_l, pwm_r, fwd_l, fwd_r, busy);
  modport slave  (input  dir_code, direction,
                  output pwm_l, pwm_r, fwd_l, fwd_r, busy);
endinterface

// File: rtl/motor_drive_ctrl_pwm_channel.sv
// One wheel's PWM: duty reloaded only at the period boundary, registered compare output.
// SOFT_START_EN: duty rises by at most DUTY_STEP per period; decreases apply in one go.
module pwm_channel #(
  parameter int PWM_PERIOD = 2500,
  parameter int DUTY_STEP  = 50,
  localparam int CNT_W     = $clog2(PWM_PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boundary,
  input  logic             force_zero,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] target,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_reg, duty_next;
  logic             pwm_reg;

`ifdef SOFT_START_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(DUTY_STEP);
`endif

  always_comb begin
    duty_next = duty_reg;
    if (force_zero) begin
      duty_next = '0;
    end else if (boundary) begin
`ifdef SOFT_START_EN
      if ((target > duty_reg) && ((target - duty_reg) > STEP)) begin
        duty_next = duty_reg + STEP;
      end else begin
        duty_next = target;
      end
`else
      duty_next = target;
`endif
    end
  end

  // Forced zero also blanks the output on the very next clock, not at the period end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_reg <= '0;
      pwm_reg  <= 1'b0;
    end else begin
      duty_reg <= duty_next;
      pwm_reg  <= !force_zero && (cnt < duty_reg);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Left/right H-bridge controller: steering decode, timed pivots, brake before reversing.
// Build option SOFT_START_EN enables the per-period duty ramp in pwm_channel.
module motor_drive_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD   = 2500,
  parameter int DUTY_CRUISE  = 2000,
  parameter int DUTY_VEER    = 1200,
  parameter int DUTY_HARD    = 400,
  parameter int PIVOT_CYCLES = 25_000_000,
  parameter int BRAKE_CYCLES = 2_500_000,
  parameter int DUTY_STEP    = 50
) (
  input  logic              clk,
  input  logic              rst,
  motor_drive_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(PWM_PERIOD);
  localparam int TMR_W = $clog2(max_int(PIVOT_CYCLES, BRAKE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] CRUISE     = CNT_W'(DUTY_CRUISE);
  localparam logic [CNT_W-1:0] VEER       = CNT_W'(DUTY_VEER);
  localparam logic [CNT_W-1:0] HARD       = CNT_W'(DUTY_HARD);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [TMR_W-1:0] PIVOT_LAST = TMR_W'(PIVOT_CYCLES - 1);
  localparam logic [TMR_W-1:0] BRAKE_LAST = TMR_W'(BRAKE_CYCLES - 1);

  drive_state_t     state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             dir_reg, dir_next;
  logic             pend_reg, pend_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] tgt_l, tgt_r;
  logic             boundary;
  logic             force_zero;
  logic [1:0]       pwm;

  assign boundary = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= boundary ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_HALT;
      timer_reg <= '0;
      dir_reg   <= 1'b1;
      pend_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      dir_reg   <= dir_next;
      pend_reg  <= pend_next;
    end
  end

  // dir_reg is the committed wheel direction; pend_reg the direction a brake is heading to.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + TMR_W'(1);
    dir_next   = dir_reg;
    pend_next  = pend_reg;
    tgt_l      = '0;
    tgt_r      = '0;
    case (state_reg)
      ST_HALT, ST_TRACK: begin
        timer_next = '0;
        pend_next  = bus.direction;
        if (bus.direction != dir_reg) begin
          state_next = ST_BRAKE;
        end else begin
          state_next = ST_TRACK;
          case (bus.dir_code)
            DIR_PROCEED:      begin tgt_l = CRUISE; tgt_r = CRUISE; end
            DIR_VEER_RIGHT:   begin tgt_l = CRUISE; tgt_r = VEER;   end
            DIR_VEER_LEFT:    begin tgt_l = VEER;   tgt_r = CRUISE; end
            DIR_HARD_RIGHT:   begin tgt_l = CRUISE; tgt_r = HARD;   end
            DIR_HARD_LEFT:    begin tgt_l = HARD;   tgt_r = CRUISE; end
            DIR_NINETY_RIGHT: begin state_next = ST_PIVOT_R; tgt_l = CRUISE; tgt_r = CRUISE; end
            DIR_NINETY_LEFT:  begin state_next = ST_PIVOT_L; tgt_l = CRUISE; tgt_r = CRUISE; end
            DIR_STOP:         state_next = ST_HALT;
            default:          state_next = ST_HALT;
          endcase
        end
      end
      ST_PIVOT_L, ST_PIVOT_R: begin
        tgt_l     = CRUISE;
        tgt_r     = CRUISE;
        pend_next = bus.direction;
        if (timer_reg == PIVOT_LAST) begin
          timer_next = '0;
          state_next = (bus.direction != dir_reg) ? ST_BRAKE : ST_TRACK;
        end
      end
      ST_BRAKE: begin
        if (bus.direction != pend_reg) begin
          pend_next  = bus.direction;
          timer_next = '0;
        end else if (timer_reg == BRAKE_LAST) begin
          state_next = ST_TRACK;
          dir_next   = pend_reg;
          timer_next = '0;
        end
      end
      default: begin
        state_next = ST_HALT;
        timer_next = '0;
      end
    endcase
  end

  assign force_zero = (state_next == ST_BRAKE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wheel
      pwm_channel #(
        .PWM_PERIOD(PWM_PERIOD),
        .DUTY_STEP (DUTY_STEP)
      ) u_pwm (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .force_zero(force_zero),
        .cnt       (cnt_reg),
        .target    ((gi == 0) ? tgt_l : tgt_r),
        .pwm       (pwm[gi])
      );
    end
  endgenerate

  assign bus.pwm_l = pwm[0];
  assign bus.pwm_r = pwm[1];
  assign bus.fwd_l = (state_reg == ST_PIVOT_L) ? ~dir_reg : dir_reg;
  assign bus.fwd_r = (state_reg == ST_PIVOT_R) ? ~dir_reg : dir_reg;
  assign bus.busy  = (state_reg == ST_PIVOT_L) || (state_reg == ST_PIVOT_R) ||
                     (state_reg == ST_BRAKE);

endmodule
